// File: rtl/a0_uart_logger.sv
// a0_uart_logger: queues every change of a0 in a small FIFO and streams queued words MSB-byte-first on an 8N1 UART line.
module a0_uart_logger #(
    parameter int DATA_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic [DATA_WIDTH-1:0]                 a0,
    output logic                                  tx,
    output logic                                  busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_count,
    output logic                                  overflow
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int BCW   = $clog2(CLKS_PER_BIT);
    localparam int YW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BCW-1:0] LAST_CLK  = BCW'(CLKS_PER_BIT - 1);
    localparam logic [YW-1:0]  LAST_BYTE = YW'(BYTES - 1);
    localparam logic [CW-1:0]  FULL      = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] prev_q, shift_q, shift_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BCW-1:0]        clk_q, clk_d;
    logic [2:0]            bit_q, bit_d;
    logic [YW-1:0]         byte_q, byte_d;
    logic                  tx_q, tx_d, ovf_q, ovf_d;
    logic                  push_req, push, pop, bit_end;
    logic [7:0]            cur_byte;

    assign cur_byte = shift_q[DATA_WIDTH-1 -: 8];
    assign bit_end  = clk_q == LAST_CLK;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        tx_d     = tx_q;
        pop      = 1'b0;
        clk_d    = (state_q == IDLE || bit_end) ? '0 : clk_q + 1'b1;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (cnt_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_q];
                    byte_d  = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: if (bit_end) begin
                bit_d   = '0;
                state_d = DATA;
                tx_d    = cur_byte[0];
            end
            DATA: if (bit_end) begin
                if (bit_q == 3'd7) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else begin
                    bit_d = bit_q + 3'd1;
                    tx_d  = cur_byte[bit_q + 3'd1];
                end
            end
            STOP: if (bit_end) begin
                // next byte of this word, else chain straight into the next queued word
                if (byte_q != LAST_BYTE) begin
                    byte_d  = byte_q + 1'b1;
                    shift_d = shift_q << 8;
                    state_d = START;
                    tx_d    = 1'b0;
                end else if (cnt_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_q];
                    byte_d  = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        push_req = en && (a0 != prev_q);
        push     = push_req && (cnt_q != FULL || pop);
        ovf_d    = ovf_q || (push_req && !push);
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        wr_d     = wr_q + AW'(push);
        rd_d     = rd_q + AW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            prev_q  <= '0;
            shift_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            clk_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= a0;
            shift_q <= shift_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            clk_q   <= clk_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= a0;
    end

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE) || (cnt_q != '0);
    assign fifo_count = cnt_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_a0_uart_logger.sv
// tb_a0_uart_logger: directed bench for a0_uart_logger with a UART receiver monitor on tx.
module tb_a0_uart_logger;
    logic        clk = 1'b0, rst = 1'b0, en = 1'b1;
    logic [31:0] a0 = '0;
    logic        tx, busy, overflow;
    logic [3:0]  fifo_count;
    int          n_checks = 0, n_errors = 0, frame_err = 0;
    bit          mon_en = 1'b1;
    logic [7:0]  rx_q [$];
    logic [7:0]  rx_b;
    logic [31:0] v [10];

    a0_uart_logger #(.DATA_WIDTH(32), .CLKS_PER_BIT(4), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .en(en), .a0(a0),
        .tx(tx), .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a0  = '0;
        en  = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        rx_q.delete();
        mon_en = 1'b1;
    endtask

    function automatic logic [31:0] pop_word();
        logic [31:0] w = '0;
        for (int k = 0; k < 4; k++) begin
            w = w << 8;
            if (rx_q.size() > 0) w[7:0] = rx_q.pop_front();
        end
        return w;
    endfunction

    // mid-bit sampling receiver; CLKS_PER_BIT = 4, so mid-bit is 2 cycles into the start bit
    initial forever begin
        tick();
        if (mon_en && !rst && tx === 1'b0) begin
            repeat (2) tick();
            if (tx !== 1'b0) frame_err++;
            for (int k = 0; k < 8; k++) begin
                repeat (4) tick();
                rx_b[k] = tx;
            end
            repeat (4) tick();
            if (tx !== 1'b1) frame_err++;
            rx_q.push_back(rx_b);
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 10; i++) v[i] = 32'h1111_1111 * (i + 1);
        #1 rst = 1'b1;
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);

        do_reset();
        a0 = 32'h1234_5678;
        tick();
        check("t1_busy_push", busy, 1);
        check("t1_count_push", fifo_count, 1);
        check("t1_tx_idle", tx, 1);
        tick();
        check("t1_tx_start", tx, 0);
        check("t1_count_pop", fifo_count, 0);
        n = 0;
        while (busy && n < 400) begin tick(); n++; end
        check("t1_frame_len", n, 160);
        check("t1_tx_end", tx, 1);
        check("t1_nbytes", rx_q.size(), 4);
        check("t1_word", pop_word(), 32'h1234_5678);

        do_reset();
        repeat (5) tick();
        check("t2_zero_busy", busy, 0);
        check("t2_zero_count", fifo_count, 0);
        a0 = 32'hDEAD_BEEF;
        repeat (500) tick();
        check("t2_nbytes", rx_q.size(), 4);
        check("t2_word", pop_word(), 32'hDEAD_BEEF);
        check("t2_tx_idle", tx, 1);
        check("t2_busy", busy, 0);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            a0 = v[i];
            tick();
            if (i == 8) begin
                check("t3_count_full", fifo_count, 8);
                check("t3_ovf_before", overflow, 0);
            end
        end
        check("t3_count_drop", fifo_count, 8);
        check("t3_ovf_after", overflow, 1);
        n = 0;
        while (busy && n < 2000) begin tick(); n++; end
        check("t3_drained", busy, 0);
        check("t3_nbytes", rx_q.size(), 36);
        for (int i = 0; i < 9; i++) check($sformatf("t3_word%0d", i), pop_word(), v[i]);
        check("t3_ovf_sticky", overflow, 1);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            a0 = v[i];
            tick();
        end
        repeat (152) tick();
        check("t4_count_pre", fifo_count, 8);
        a0 = 32'hCAFE_F00D;
        tick();
        check("t4_count_same", fifo_count, 8);
        check("t4_ovf", overflow, 0);
        check("t4_tx_nogap", tx, 0);
        n = 0;
        while (busy && n < 2000) begin tick(); n++; end
        check("t4_drained", busy, 0);
        check("t4_nbytes", rx_q.size(), 40);
        for (int i = 0; i < 9; i++) check($sformatf("t4_word%0d", i), pop_word(), v[i]);
        check("t4_word_new", pop_word(), 32'hCAFE_F00D);
        check("t4_ovf_end", overflow, 0);

        do_reset();
        mon_en = 1'b0;
        a0 = 32'hFFFF_00FF;
        tick();
        a0 = 32'h0000_0001;
        tick();
        repeat (97) tick();
        check("t5_tx_data0", tx, 0);
        check("t5_busy_pre", busy, 1);
        check("t5_count_pre", fifo_count, 1);
        #2 rst = 1'b1;
        a0 = '0;
        #1;
        check("t5_tx_rst", tx, 1);
        check("t5_busy_rst", busy, 0);
        check("t5_count_rst", fifo_count, 0);
        repeat (2) tick();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (tx === 1'b1 && busy === 1'b0) n++;
        end
        check("t5_quiet", n, 200);

        do_reset();
        en = 1'b0;
        a0 = 32'h1; tick();
        a0 = 32'h2; tick();
        a0 = 32'h3; tick();
        en = 1'b1;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx === 1'b1 && busy === 1'b0 && fifo_count === 4'd0) n++;
        end
        check("t6_quiet", n, 60);
        check("t6_nbytes", rx_q.size(), 0);
        check("frame_err", frame_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
